// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, ALU select codes and the
// ISSUE->EX bundle for the ALU issue/writeback slice.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int NREGS  = 8;
    localparam int REG_AW = 3;
    localparam int OP_W   = 3;

    // Codes 3'b110 and 3'b111 both pass operand A through.
    typedef enum logic [OP_W-1:0] {
        ADD  = 3'b000,
        SUB  = 3'b001,
        AND  = 3'b010,
        OR   = 3'b011,
        NOT  = 3'b100,
        CLR  = 3'b101,
        PASS = 3'b110
    } alu_op_e;

    // Control half of the EX register; operands live on alu_a/alu_b.
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
    } id_ex_t;

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREGS x DATA_W register file, r0 reads as zero.
// Ports: 2 async read ports (a/b), EX write port, external write
// port; EX wins when both write the same register in one edge.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we_ex,
    input  logic [REG_AW-1:0] waddr_ex,
    input  logic [DATA_W-1:0] wdata_ex,
    input  logic              we_ext,
    input  logic [REG_AW-1:0] waddr_ext,
    input  logic [DATA_W-1:0] wdata_ext
);

    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            // r0 is never written, so it stays at its reset zero.
            for (int i = 1; i < NREGS; i++) begin
                if (we_ex && waddr_ex == REG_AW'(i)) begin
                    regs[i] <= wdata_ex;
                end else if (we_ext && waddr_ext == REG_AW'(i)) begin
                    regs[i] <= wdata_ext;
                end
            end
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: operand issue + writeback around an external ALU.
// Ports: in_* valid/ready instruction, stall, ext_* regfile load,
// alu_a/alu_b/alu_sel to ALU, alu_result back, wb_* and retire_count.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic              in_imm_en,
    input  logic [DATA_W-1:0] in_imm,
    input  logic              stall,
    input  logic              ext_we,
    input  logic [REG_AW-1:0] ext_waddr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic [15:0]       retire_count
);

    id_ex_t            ex_q;
    logic              accept;
    logic              wb_fire;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] src_b;

    // An ext write owns the cycle; the issue slot is refused.
    assign in_ready = ~stall & ~ext_we;
    assign accept   = in_valid & in_ready;
    assign wb_fire  = ex_q.valid & ~stall;

    alu_regfile u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a   (in_rs1),
        .rdata_a   (rf_a),
        .raddr_b   (in_rs2),
        .rdata_b   (rf_b),
        .we_ex     (wb_fire),
        .waddr_ex  (ex_q.rd),
        .wdata_ex  (alu_result),
        .we_ext    (ext_we),
        .waddr_ext (ext_waddr),
        .wdata_ext (ext_wdata)
    );

    // Bypass only from a result that retires this edge; a nonzero
    // source that matches implies ex_rd is nonzero as well.
    always_comb begin
        op_a = rf_a;
        unique case (1'b1)
            (in_rs1 == '0): op_a = '0;
            (in_rs1 != '0 && wb_fire && ex_q.rd == in_rs1):
                op_a = alu_result;
            default: op_a = rf_a;
        endcase
    end

    always_comb begin
        src_b = rf_b;
        unique case (1'b1)
            (in_rs2 == '0): src_b = '0;
            (in_rs2 != '0 && wb_fire && ex_q.rd == in_rs2):
                src_b = alu_result;
            default: src_b = rf_b;
        endcase
    end

    assign op_b = in_imm_en ? in_imm : src_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_sel <= CLR;
        end else if (accept) begin
            ex_q.valid <= 1'b1;
            ex_q.rd    <= in_rd;
            alu_a      <= op_a;
            alu_b      <= op_b;
            alu_sel    <= in_op;
        end else if (!stall) begin
            ex_q.valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            retire_count <= '0;
        end else if (wb_fire) begin
            wb_valid     <= 1'b1;
            wb_rd        <= ex_q.rd;
            wb_data      <= alu_result;
            retire_count <= retire_count + 16'd1;
        end else begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed + random check of alu_issue_stage
// against an in-order architectural model of the register file.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic        in_imm_en;
    logic [15:0] in_imm;
    logic        stall;
    logic        ext_we;
    logic [2:0]  ext_waddr;
    logic [15:0] ext_wdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_result;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic [15:0] retire_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Architectural model: register values in program order plus
    // the one instruction that has issued but not yet retired.
    logic [15:0] m_regs [8];
    bit          m_pv;
    logic [2:0]  m_prd;
    logic [15:0] m_pres;
    logic [15:0] e_a;
    logic [15:0] e_b;
    logic [2:0]  e_sel;
    bit          e_wbv;
    logic [2:0]  e_wbrd;
    logic [15:0] e_wbd;
    logic [15:0] e_cnt;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(logic [15:0] a,
                                          logic [15:0] b,
                                          logic [2:0] s);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return ~a;
            3'd5: return 16'h0;
            default: return a;
        endcase
    endfunction

    assign alu_result = alu_f(alu_a, alu_b, alu_sel);

    alu_issue_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_op        (in_op),
        .in_rd        (in_rd),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_imm_en    (in_imm_en),
        .in_imm       (in_imm),
        .stall        (stall),
        .ext_we       (ext_we),
        .ext_waddr    (ext_waddr),
        .ext_wdata    (ext_wdata),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_sel      (alu_sel),
        .alu_result   (alu_result),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .retire_count (retire_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(logic [2:0] s);
        if (s == 3'd0) return 16'h0;
        if (m_pv && m_prd == s) return m_pres;
        return m_regs[s];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        m_pv   = 1'b0;
        m_prd  = 3'd0;
        m_pres = 16'h0;
        e_a    = 16'h0;
        e_b    = 16'h0;
        e_sel  = 3'b101;
        e_wbv  = 1'b0;
        e_wbrd = 3'd0;
        e_wbd  = 16'h0;
        e_cnt  = 16'h0;
    endtask

    task automatic set_idle();
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_rd     = 3'd0;
        in_rs1    = 3'd0;
        in_rs2    = 3'd0;
        in_imm_en = 1'b0;
        in_imm    = 16'h0;
        stall     = 1'b0;
        ext_we    = 1'b0;
        ext_waddr = 3'd0;
        ext_wdata = 16'h0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_alu_a"}, alu_a, 16'h0);
        chk({tag, "_alu_b"}, alu_b, 16'h0);
        chk({tag, "_alu_sel"}, alu_sel, 3'b101);
        chk({tag, "_wb_valid"}, wb_valid, 1'b0);
        chk({tag, "_wb_rd"}, wb_rd, 3'd0);
        chk({tag, "_wb_data"}, wb_data, 16'h0);
        chk({tag, "_count"}, retire_count, 16'h0);
    endtask

    task automatic step(input bit v, input logic [2:0] op,
                        input logic [2:0] rd, input logic [2:0] rs1,
                        input logic [2:0] rs2, input bit ie,
                        input logic [15:0] imm, input bit st,
                        input bit ew, input logic [2:0] wa,
                        input logic [15:0] wd);
        bit          acc;
        bit          wb;
        logic [15:0] a;
        logic [15:0] b;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_imm_en = ie;
        in_imm    = imm;
        stall     = st;
        ext_we    = ew;
        ext_waddr = wa;
        ext_wdata = wd;
        #1;
        chk("in_ready", in_ready, !st && !ew);
        acc = v && !st && !ew;
        wb  = m_pv && !st;
        a   = m_read(rs1);
        b   = ie ? imm : m_read(rs2);
        @(posedge clk);
        #1;
        if (ew && wa != 3'd0) m_regs[wa] = wd;
        if (wb) begin
            if (m_prd != 3'd0) m_regs[m_prd] = m_pres;
            e_wbv  = 1'b1;
            e_wbrd = m_prd;
            e_wbd  = m_pres;
            e_cnt  = e_cnt + 16'd1;
        end else begin
            e_wbv = 1'b0;
        end
        if (acc) begin
            e_a    = a;
            e_b    = b;
            e_sel  = op;
            m_pv   = 1'b1;
            m_prd  = rd;
            m_pres = alu_f(a, b, op);
        end else if (!st) begin
            m_pv = 1'b0;
        end
        chk("alu_a", alu_a, e_a);
        chk("alu_b", alu_b, e_b);
        chk("alu_sel", alu_sel, e_sel);
        chk("wb_valid", wb_valid, e_wbv);
        chk("wb_rd", wb_rd, e_wbrd);
        chk("wb_data", wb_data, e_wbd);
        chk("retire_count", retire_count, e_cnt);
    endtask

    task automatic idle();
        step(0, 3'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0, 0, 0, 3'd0, 16'h0);
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] rd,
                         input logic [2:0] rs1, input logic [2:0] rs2);
        step(1, op, rd, rs1, rs2, 0, 16'h0, 0, 0, 3'd0, 16'h0);
    endtask

    task automatic ext(input logic [2:0] wa, input logic [15:0] wd);
        step(0, 3'd0, 3'd0, 3'd0, 3'd0, 0, 16'h0, 0, 1, wa, wd);
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset("por");
        chk("por_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD r3 = r1 + r2
        ext(3'd1, 16'h0005);
        ext(3'd2, 16'h0003);
        issue(ADD, 3'd3, 3'd1, 3'd2);
        chk("add_a", alu_a, 16'h0005);
        chk("add_b", alu_b, 16'h0003);

        // dependent SUB r4 = r3 - r1 via bypass
        issue(SUB, 3'd4, 3'd3, 3'd1);
        chk("add_wb_valid", wb_valid, 1'b1);
        chk("add_wb_rd", wb_rd, 3'd3);
        chk("add_wb_data", wb_data, 16'h0008);
        chk("add_count", retire_count, 16'd1);
        chk("byp_a", alu_a, 16'h0008);
        idle();
        chk("sub_wb_data", wb_data, 16'h0003);

        // stall with EX valid
        issue(ADD, 3'd6, 3'd1, 3'd1);
        for (int i = 0; i < 3; i++) begin
            step(1, SUB, 3'd7, 3'd1, 3'd1, 0, 16'h0, 1, 0, 3'd0, 16'h0);
            chk("stall_hold_a", alu_a, 16'h0005);
            chk("stall_wb_valid", wb_valid, 1'b0);
        end
        idle();
        chk("stall_rel_data", wb_data, 16'h000A);
        chk("stall_rel_count", retire_count, 16'd3);
        idle();
        chk("stall_single_wb", wb_valid, 1'b0);

        // r0 destination and r0 source
        ext(3'd7, 16'h1234);
        issue(ADD, 3'd0, 3'd7, 3'd0);
        issue(ADD, 3'd1, 3'd0, 3'd0);
        chk("r0_no_bypass", alu_a, 16'h0000);
        chk("r0_wb_rd", wb_rd, 3'd0);
        chk("r0_wb_data", wb_data, 16'h1234);
        idle();

        // ext and EX writeback collide on r5
        step(1, ADD, 3'd5, 3'd0, 3'd0, 1, 16'h5555, 0, 0, 3'd0, 16'h0);
        step(1, ADD, 3'd2, 3'd0, 3'd0, 0, 16'h0, 0, 1, 3'd5, 16'hAAAA);
        issue(PASS, 3'd1, 3'd5, 3'd0);
        chk("collide_r5", alu_a, 16'h5555);
        idle();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0,
                 16'($urandom), $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)),
                 16'($urandom));
        end

        // reset with EX valid
        issue(ADD, 3'd3, 3'd1, 3'd2);
        @(negedge clk);
        set_idle();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_reset("arst");
        @(posedge clk);
        #1;
        chk("arst_no_wb", wb_valid, 1'b0);
        chk("arst_no_count", retire_count, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(PASS, 3'd1, 3'd3, 3'd4);
        chk("arst_regs_zero_a", alu_a, 16'h0000);
        chk("arst_regs_zero_b", alu_b, 16'h0000);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Operand-issue and writeback stage directly upstream of the 16-bit ALU. Accepts decoded instructions over a valid/ready handshake and reads two source registers from an internal 8x16 register file, with bypass from the in-flight result. Drives registered A, B and select to the ALU, then writes the ALU result back to the destination register. Provides a single-cycle-throughput, two-stage pipeline (ISSUE -> EX/WB) with downstream stall and an external register-load port.

Parameters:
DATA_W, 16, operand/result width
NREGS, 8, register-file depth; r0 hardwired to zero
REG_AW, 3, register address width (log2 NREGS)
OP_W, 3, ALU select width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction valid
in_ready  out  1  stage can accept; combinational = ~stall & ~ext_we
in_op  in  OP_W  ALU select code
in_rd  in  REG_AW  destination register
in_rs1  in  REG_AW  source A register
in_rs2  in  REG_AW  source B register
in_imm_en  in  1  1: B operand = in_imm instead of rs2
in_imm  in  DATA_W  immediate
stall  in  1  downstream hold
ext_we  in  1  external register write enable
ext_waddr  in  REG_AW  external write address
ext_wdata  in  DATA_W  external write data
alu_a  out  DATA_W  registered ALU operand A
alu_b  out  DATA_W  registered ALU operand B
alu_sel  out  OP_W  registered ALU select
alu_result  in  DATA_W  combinational ALU output for current alu_a/alu_b/alu_sel
wb_valid  out  1  registered pulse: a writeback occurred last edge
wb_rd  out  REG_AW  register written
wb_data  out  DATA_W  value written
retire_count  out  16  number of writebacks, wraps 0xFFFF->0

Behaviour:
- Reset (async, rst_n=0): all registers 0; ex_valid=0; alu_a=alu_b=0; alu_sel=CLR (3'b101); wb_valid=0, wb_rd=0, wb_data=0; retire_count=0. In-flight EX instruction discarded; no writeback.
- Accept: in_valid & in_ready at edge. EX register loads alu_a, alu_b, alu_sel=in_op, ex_rd=in_rd, ex_valid=1.
- If no accept and ~stall: ex_valid<=0; alu_a, alu_b and alu_sel hold their values.
- Operand read (combinational, ISSUE cycle): src==0 -> 0; else if ex_valid & ~stall & ex_rd==src & ex_rd!=0 -> alu_result (bypass); else regfile[src]. B uses in_imm when in_imm_en=1.
- Writeback: at an edge with ex_valid & ~stall: regfile[ex_rd]<=alu_result (ignored if ex_rd==0). wb_valid<=1, wb_rd<=ex_rd, wb_data<=alu_result, retire_count+=1 (counts r0 writes too). Otherwise wb_valid<=0 and wb_rd/wb_data hold.
- Stall=1: EX register, ex_valid and alu_* hold; no writeback; in_ready=0; wb_valid<=0.
- Latency: instruction accepted at edge N; its result is in regfile and wb_* at edge N+1. Back-to-back dependent instructions issue every cycle via bypass.
- ext_we: writes regfile[ext_waddr]<=ext_wdata at edge (r0 ignored); forces in_ready=0; no bypass from ext write (visible next cycle). If ext write and EX writeback target the same register at the same edge, EX writeback wins.
- Results are truncated to DATA_W; the stage does no arithmetic itself.

Decomposition:
- Package alu_pkg: DATA_W/REG_AW/OP_W constants; alu_op_e enum ADD=000, SUB=001, AND=010, OR=011, NOT=100, CLR=101, PASS (others: A passes through).
- Sub-module alu_regfile: NREGS x DATA_W, 2 async read ports, 2 write ports (EX port priority over ext port), r0 reads 0.

Test Plan:
- ext write r1=0x0005, r2=0x0003; issue ADD rd=3,rs1=1,rs2=2 -> alu_a=5, alu_b=3; next cycle wb_valid=1, wb_rd=3, wb_data=0x0008, retire_count=1.
- Back-to-back: ADD r3=r1+r2 then SUB r4=r3-r1 on consecutive cycles -> second alu_a=0x0008 (bypassed), wb_data=0x0003.
- stall=1 for 3 cycles with EX valid -> alu_* hold, in_ready=0, wb_valid=0; release -> single writeback, count+1.
- r0: ADD rd=0 with result 0x1234, then read rs1=0 -> operand 0, no bypass; wb_valid=1, wb_rd=0, count increments.
- Same-edge ext_we r5=0xAAAA and EX writeback r5=0x5555 -> r5=0x5555; in_ready=0 that cycle.
- Reset asserted while EX is valid -> no writeback; all outputs at reset values; alu_sel=3'b101; registers read 0.
